// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN execution stage.
//   opcode_e   : 3-bit opcode field of an instruction (PUSH..CLR)
//   state_e    : IDLE / EXEC / DONE sequencing states
//   err_code_e : sticky error code reported on err_code
//   OPC_MSB/OPC_LSB, IMM_MSB/IMM_LSB : instruction field positions
package rpn_pkg;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int IMM_MSB = 4;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    typedef enum logic [2:0] {
        OP_PUSH = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_DUP  = 3'b100,
        OP_SWAP = 3'b101,
        OP_DROP = 3'b110,
        OP_CLR  = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_UNDERFLOW = 2'b01,
        ERR_OVERFLOW  = 2'b10,
        ERR_DROPPED   = 2'b11
    } err_code_e;

endpackage

// File: rtl/rpn_alu.sv
// Combinational arithmetic for the RPN stage.
//   a      : next-of-stack (left operand)
//   b      : top-of-stack (right operand)
//   opcode : instruction opcode; ADD/SUB/MUL produce a result, others pass b
//   result : a+b, a-b or low DATA_W bits of a*b
// Build option: RPN_SAT_EN defined -> unsigned saturation (ADD/MUL clamp to
// all-ones, SUB clamps to zero); undefined -> wrap-around modulo 2**DATA_W.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        opcode,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] sum_val;
    logic [DATA_W-1:0] diff_val;
    logic [DATA_W-1:0] prod_val;

`ifdef RPN_SAT_EN
    logic [DATA_W:0]     sum_full;
    logic [DATA_W:0]     diff_full;
    logic [2*DATA_W-1:0] prod_full;

    assign sum_full  = {1'b0, a} + {1'b0, b};
    assign diff_full = {1'b0, a} - {1'b0, b};
    assign prod_full = (2*DATA_W)'(a) * (2*DATA_W)'(b);

    // Carry out / borrow / any high product bit means the result left the range.
    assign sum_val  = sum_full[DATA_W]  ? '1 : sum_full[DATA_W-1:0];
    assign diff_val = diff_full[DATA_W] ? '0 : diff_full[DATA_W-1:0];
    assign prod_val = (|prod_full[2*DATA_W-1:DATA_W]) ? '1 : prod_full[DATA_W-1:0];
`else
    assign sum_val  = a + b;
    assign diff_val = a - b;
    assign prod_val = a * b;
`endif

    always_comb begin
        result = b;
        case (opcode_e'(opcode))
            OP_ADD:  result = sum_val;
            OP_SUB:  result = diff_val;
            OP_MUL:  result = prod_val;
            default: result = b;
        endcase
    end

endmodule

// File: rtl/rpn_exec.sv
// RPN execution stage: takes one 8-bit instruction per instr_valid strobe and
// runs it against an on-chip operand stack.
//   CLOCK_50    : clock, all state changes on rising edge
//   rst         : synchronous active-high reset
//   instr_valid : one-cycle strobe, instr holds a new instruction
//   instr       : [7:5] opcode, [4:0] imm5
//   busy        : high while the instruction executes (EXEC)
//   done        : one-cycle pulse when the instruction retires (DONE)
//   top / next  : stack[depth-1] / stack[depth-2], zero when not present
//   depth       : occupied entries
//   err         : sticky error flag; err_code 00 none, 01 underflow,
//                 10 overflow, 11 dropped strobe
// Build option: RPN_SAT_EN selects saturating arithmetic inside rpn_alu.
module rpn_exec
    import rpn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       CLOCK_50,
    input  logic                       rst,
    input  logic                       instr_valid,
    input  logic [7:0]                 instr,
    output logic                       busy,
    output logic                       done,
    output logic [DATA_W-1:0]          top,
    output logic [DATA_W-1:0]          next,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       err,
    output logic [1:0]                 err_code
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    state_e            state_reg, state_next;
    logic [7:0]        instr_reg, instr_next;
    logic [PTR_W-1:0]  depth_reg, depth_next;
    logic              err_reg, err_next;
    err_code_e         err_code_reg, err_code_next;

    logic [DATA_W-1:0] stack_q [DEPTH];

    // Two write ports: port a serves every op, port b only the second half of SWAP.
    logic              wr_en_a, wr_en_b;
    logic [IDX_W-1:0]  wr_idx_a, wr_idx_b;
    logic [DATA_W-1:0] wr_data_a, wr_data_b;

    logic [IDX_W-1:0]  top_idx, nxt_idx, push_idx;
    logic [DATA_W-1:0] top_val, next_val, alu_result;
    logic              is_empty, is_full, has_two;
    opcode_e           opcode;
    logic [IMM_W-1:0]  imm;

    assign opcode   = opcode_e'(instr_reg[OPC_MSB:OPC_LSB]);
    assign imm      = instr_reg[IMM_MSB:IMM_LSB];

    assign is_empty = (depth_reg == '0);
    assign is_full  = (depth_reg == PTR_W'(DEPTH));
    assign has_two  = (depth_reg >= PTR_W'(2));

    // Index truncation is harmless: these are only used when in range.
    assign top_idx  = IDX_W'(depth_reg - PTR_W'(1));
    assign nxt_idx  = IDX_W'(depth_reg - PTR_W'(2));
    assign push_idx = IDX_W'(depth_reg);

    assign top_val  = is_empty ? '0 : stack_q[top_idx];
    assign next_val = has_two  ? stack_q[nxt_idx] : '0;

    rpn_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (next_val),
        .b      (top_val),
        .opcode (instr_reg[OPC_MSB:OPC_LSB]),
        .result (alu_result)
    );

    // Stack storage: one register per entry; entries need no reset because
    // depth masks everything above the occupied region.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stack
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge CLOCK_50) begin
                if (wr_en_a && (wr_idx_a == IDX_W'(gi))) begin
                    entry_reg <= wr_data_a;
                end else if (wr_en_b && (wr_idx_b == IDX_W'(gi))) begin
                    entry_reg <= wr_data_b;
                end
            end

            assign stack_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            instr_reg    <= '0;
            depth_reg    <= '0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            instr_reg    <= instr_next;
            depth_reg    <= depth_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
        end
    end

    // Sequencing: a new strobe is accepted in IDLE and in DONE, so
    // instructions can be issued back to back every two cycles.
    always_comb begin
        state_next = state_reg;
        instr_next = instr_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (instr_valid) begin
                    state_next = ST_EXEC;
                    instr_next = instr;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_EXEC: state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Execution: commits at the edge that ends EXEC. Errors leave the stack
    // untouched. A strobe dropped during the same EXEC cycle is recorded after
    // the instruction's own outcome, so it wins the sticky code (even over CLR).
    always_comb begin
        depth_next    = depth_reg;
        err_next      = err_reg;
        err_code_next = err_code_reg;
        wr_en_a       = 1'b0;
        wr_idx_a      = push_idx;
        wr_data_a     = alu_result;
        wr_en_b       = 1'b0;
        wr_idx_b      = top_idx;
        wr_data_b     = next_val;

        if (state_reg == ST_EXEC) begin
            case (opcode)
                OP_PUSH: begin
                    if (is_full) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_OVERFLOW;
                    end else begin
                        wr_en_a    = 1'b1;
                        wr_idx_a   = push_idx;
                        wr_data_a  = DATA_W'(imm);
                        depth_next = depth_reg + PTR_W'(1);
                    end
                end
                OP_ADD, OP_SUB, OP_MUL: begin
                    if (!has_two) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_UNDERFLOW;
                    end else begin
                        wr_en_a    = 1'b1;
                        wr_idx_a   = nxt_idx;
                        wr_data_a  = alu_result;
                        depth_next = depth_reg - PTR_W'(1);
                    end
                end
                OP_DUP: begin
                    if (is_empty) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_UNDERFLOW;
                    end else if (is_full) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_OVERFLOW;
                    end else begin
                        wr_en_a    = 1'b1;
                        wr_idx_a   = push_idx;
                        wr_data_a  = top_val;
                        depth_next = depth_reg + PTR_W'(1);
                    end
                end
                OP_SWAP: begin
                    if (!has_two) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_UNDERFLOW;
                    end else begin
                        wr_en_a   = 1'b1;
                        wr_idx_a  = nxt_idx;
                        wr_data_a = top_val;
                        wr_en_b   = 1'b1;
                        wr_idx_b  = top_idx;
                        wr_data_b = next_val;
                    end
                end
                OP_DROP: begin
                    if (is_empty) begin
                        err_next      = 1'b1;
                        err_code_next = ERR_UNDERFLOW;
                    end else begin
                        depth_next = depth_reg - PTR_W'(1);
                    end
                end
                OP_CLR: begin
                    depth_next    = '0;
                    err_next      = 1'b0;
                    err_code_next = ERR_NONE;
                end
                default: ;
            endcase

            if (instr_valid) begin
                err_next      = 1'b1;
                err_code_next = ERR_DROPPED;
            end
        end
    end

    assign busy     = (state_reg == ST_EXEC);
    assign done     = (state_reg == ST_DONE);
    assign top      = top_val;
    assign next     = next_val;
    assign depth    = depth_reg;
    assign err      = err_reg;
    assign err_code = err_code_reg;

endmodule

// File: tb/tb_rpn_exec.sv
module tb_rpn_exec;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int MAXV   = (1 << DATA_W) - 1;

    logic             CLOCK_50 = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic [7:0]       instr;
    logic             busy, done;
    logic [DATA_W-1:0] top, next;
    logic [3:0]       depth;
    logic             err;
    logic [1:0]       err_code;

    rpn_exec #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLOCK_50    (CLOCK_50),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .busy        (busy),
        .done        (done),
        .top         (top),
        .next        (next),
        .depth       (depth),
        .err         (err),
        .err_code    (err_code)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    // Reference model: stack as a queue, back = top of stack.
    int mstk[$];
    int merr;
    int mcode;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int arith(input int op, input int a, input int b);
        int r;
        case (op)
            1:       r = a + b;
            2:       r = a - b;
            default: r = a * b;
        endcase
`ifdef RPN_SAT_EN
        if (r > MAXV) r = MAXV;
        if (r < 0) r = 0;
`else
        r = r & MAXV;
`endif
        return r;
    endfunction

    task automatic set_err(input int code);
        merr  = 1;
        mcode = code;
    endtask

    task automatic model_exec(input int op, input int imm, input bit drop);
        int d;
        int a, b;
        d = mstk.size();
        case (op)
            0: if (d == DEPTH) set_err(2); else mstk.push_back(imm);
            1, 2, 3: begin
                if (d < 2) set_err(1);
                else begin
                    b = mstk.pop_back();
                    a = mstk.pop_back();
                    mstk.push_back(arith(op, a, b));
                end
            end
            4: begin
                if (d < 1) set_err(1);
                else if (d == DEPTH) set_err(2);
                else mstk.push_back(mstk[d-1]);
            end
            5: begin
                if (d < 2) set_err(1);
                else begin
                    a = mstk[d-1];
                    mstk[d-1] = mstk[d-2];
                    mstk[d-2] = a;
                end
            end
            6: if (d < 1) set_err(1); else void'(mstk.pop_back());
            default: begin
                mstk.delete();
                merr  = 0;
                mcode = 0;
            end
        endcase
        if (drop) set_err(3);
    endtask

    task automatic model_reset();
        mstk.delete();
        merr  = 0;
        mcode = 0;
    endtask

    task automatic check_state(input string pfx);
        int d;
        d = mstk.size();
        chk({pfx, "_depth"}, int'(depth), d);
        chk({pfx, "_top"},   int'(top),  (d > 0) ? mstk[d-1] : 0);
        chk({pfx, "_next"},  int'(next), (d > 1) ? mstk[d-2] : 0);
        chk({pfx, "_err"},   int'(err),  merr);
        chk({pfx, "_code"},  int'(err_code), mcode);
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic issue(input int op, input int imm, input bit drop);
        logic [7:0] w;
        int         opv, immv;
        opv  = op;
        immv = imm;
        w    = {opv[2:0], immv[4:0]};
        instr       = w;
        instr_valid = 1'b1;
        @(negedge CLOCK_50);
        if (drop) begin
            instr       = 8'($urandom);
            instr_valid = 1'b1;
        end else begin
            instr_valid = 1'b0;
        end
        chk("busy_exec", int'(busy), 1);
        chk("done_exec", int'(done), 0);
        @(negedge CLOCK_50);
        instr_valid = 1'b0;
        model_exec(op, imm, drop);
        chk("done_pulse", int'(done), 1);
        chk("busy_done",  int'(busy), 0);
        check_state("st");
        $display("op=%0d imm=%0d drop=%0d -> top=%0d next=%0d depth=%0d err=%0d code=%0d",
                 op, imm, drop, top, next, depth, err, err_code);
    endtask

    task automatic idle_gap();
        @(negedge CLOCK_50);
        chk("done_low", int'(done), 0);
        chk("busy_low", int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, op, imm;
        bit drop;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        repeat (2) @(negedge CLOCK_50);
        rst = 1'b0;
        model_reset();
        chk("rst_depth", int'(depth), 0);
        chk("rst_top",   int'(top),   0);
        chk("rst_next",  int'(next),  0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        chk("rst_err",   int'(err),   0);
        chk("rst_code",  int'(err_code), 0);

        // 5 - 3
        issue(0, 5, 0);
        issue(0, 3, 0);
        issue(2, 0, 0);
        chk("sub_top", int'(top), 2);
        chk("sub_depth", int'(depth), 1);
        issue(7, 0, 0);

        // 31 * 31 = 0x3C1
        issue(0, 31, 0);
        issue(0, 31, 0);
        issue(3, 0, 0);
`ifdef RPN_SAT_EN
        chk("mul_top", int'(top), 8'hFF);
`else
        chk("mul_top", int'(top), 8'hC1);
`endif
        issue(7, 0, 0);

        // 0 - 1
        issue(0, 0, 0);
        issue(0, 1, 0);
        issue(2, 0, 0);
`ifdef RPN_SAT_EN
        chk("sub0_top", int'(top), 8'h00);
`else
        chk("sub0_top", int'(top), 8'hFF);
`endif
        issue(7, 0, 0);
        idle_gap();

        // ADD with a single operand
        issue(0, 4, 0);
        issue(1, 0, 0);
        chk("uf_err", int'(err), 1);
        chk("uf_code", int'(err_code), 1);
        chk("uf_depth", int'(depth), 1);
        chk("uf_top", int'(top), 4);
        issue(7, 0, 0);
        chk("clr_err", int'(err), 0);
        chk("clr_depth", int'(depth), 0);

        // Fill then overflow
        for (int i = 0; i < DEPTH + 1; i++) issue(0, i + 10, 0);
        chk("of_depth", int'(depth), DEPTH);
        chk("of_code", int'(err_code), 2);
        chk("of_top", int'(top), DEPTH - 1 + 10);
        issue(7, 0, 0);

        // Strobe while busy
        issue(0, 9, 1);
        chk("drop_code", int'(err_code), 3);
        chk("drop_depth", int'(depth), 1);
        issue(7, 0, 0);
        idle_gap();

        // Reset during EXEC of PUSH 7
        instr       = {3'b000, 5'd7};
        instr_valid = 1'b1;
        @(negedge CLOCK_50);
        instr_valid = 1'b0;
        chk("rx_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge CLOCK_50);
        chk("rx_depth", int'(depth), 0);
        chk("rx_done", int'(done), 0);
        chk("rx_busy0", int'(busy), 0);
        rst = 1'b0;
        model_reset();
        idle_gap();
        check_state("rx");

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if      (r < 35) op = 0;
            else if (r < 45) op = 1;
            else if (r < 55) op = 2;
            else if (r < 62) op = 3;
            else if (r < 72) op = 4;
            else if (r < 80) op = 5;
            else if (r < 92) op = 6;
            else             op = 7;
            imm  = $urandom_range(0, 31);
            drop = ($urandom_range(0, 9) == 0);
            issue(op, imm, drop);
            if ($urandom_range(0, 2) == 0) idle_gap();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
